// File: rtl/beam_decimator.sv
// Boxcar decimator for the beam adder tree: sums 2^DEC_LOG2 samples, rounds,
// shifts and saturates each frame, then queues words in a small output FIFO.
module beam_decimator #(
   parameter int IN_W       = 22,
   parameter int DEC_LOG2   = 3,
   parameter int SHIFT      = 9,
   parameter int OUT_W      = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic signed [IN_W-1:0]        in_sum,
   input  logic                          in_valid,
   output logic signed [OUT_W-1:0]       out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          sat_sticky,
   output logic                          drop_sticky,
   input  logic                          clr_flags
);

   localparam int ACC_W = IN_W + DEC_LOG2;
   localparam int RND_W = ACC_W + 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   localparam logic [DEC_LOG2-1:0]     CNT_LAST = '1;
   localparam logic signed [RND_W-1:0] RND_HALF = RND_W'(64'sd1 <<< (SHIFT - 1));
   localparam logic signed [RND_W-1:0] SAT_MAX  = RND_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
   localparam logic signed [RND_W-1:0] SAT_MIN  = RND_W'(-(64'sd1 <<< (OUT_W - 1)));
   localparam logic [LVL_W-1:0]        LVL_FULL = LVL_W'(FIFO_DEPTH);

   logic signed [ACC_W-1:0]  acc;
   logic [DEC_LOG2-1:0]      cnt;
   logic signed [ACC_W-1:0]  full_sum;
   logic signed [RND_W-1:0]  rnd_sum;
   logic signed [RND_W-1:0]  rnd_sh;
   logic signed [OUT_W-1:0]  word;
   logic                     clamp;

   logic [OUT_W-1:0]         mem [FIFO_DEPTH];
   logic [PTR_W-1:0]         wr_ptr, rd_ptr;
   logic [LVL_W-1:0]         level;
   logic                     push, pop, push_ok, drop;

   // One extra bit of headroom so the rounding offset cannot wrap the sum.
   always_comb begin
      full_sum = acc + {{DEC_LOG2{in_sum[IN_W-1]}}, in_sum};
      rnd_sum  = {full_sum[ACC_W-1], full_sum} + RND_HALF;
      rnd_sh   = rnd_sum >>> SHIFT;
      clamp    = 1'b0;
      word     = rnd_sh[OUT_W-1:0];
      if (rnd_sh > SAT_MAX) begin
         clamp = 1'b1;
         word  = SAT_MAX[OUT_W-1:0];
      end else if (rnd_sh < SAT_MIN) begin
         clamp = 1'b1;
         word  = SAT_MIN[OUT_W-1:0];
      end
   end

   assign push    = in_valid && (cnt == CNT_LAST);
   assign pop     = out_valid && out_ready;
   assign push_ok = push && ((level != LVL_FULL) || pop);
   assign drop    = push && (level == LVL_FULL) && !pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         cnt <= '0;
      end else if (in_valid) begin
         if (push) begin
            acc <= '0;
            cnt <= '0;
         end else begin
            acc <= full_sum;
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Storage is reset so the head reads 0 out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= word;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         level <= level + LVL_W'(push_ok) - LVL_W'(pop);
      end
   end

   // A set in the same cycle as a clear takes priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_sticky  <= 1'b0;
         drop_sticky <= 1'b0;
      end else begin
         if (push && clamp)  sat_sticky <= 1'b1;
         else if (clr_flags) sat_sticky <= 1'b0;
         if (drop)           drop_sticky <= 1'b1;
         else if (clr_flags) drop_sticky <= 1'b0;
      end
   end

   assign out_data   = mem[rd_ptr];
   assign out_valid  = (level != '0);
   assign fifo_level = level;

endmodule

// File: tb/tb_beam_decimator.sv
// Directed bench for beam_decimator: hand-computed frame results, FIFO fill,
// drop, simultaneous push/pop at full, and mid-frame reset.
module tb_beam_decimator;

   logic               clk = 1'b0;
   logic               rst_n;
   logic signed [21:0] in_sum;
   logic               in_valid;
   logic signed [15:0] out_data;
   logic               out_valid;
   logic               out_ready;
   logic [2:0]         fifo_level;
   logic               sat_sticky;
   logic               drop_sticky;
   logic               clr_flags;

   int n_chk  = 0;
   int n_fail = 0;

   beam_decimator dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_sum      (in_sum),
      .in_valid    (in_valid),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .fifo_level  (fifo_level),
      .sat_sticky  (sat_sticky),
      .drop_sticky (drop_sticky),
      .clr_flags   (clr_flags)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drives one frame of 8 equal samples on negedges; optional idle gap between
   // samples, optional out_ready pulse aligned with the completing sample.
   task automatic send_frame(input int val, input int gap, input bit rdy_last);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         in_sum   = 22'(val);
         in_valid = 1'b1;
         if (rdy_last && i == 7) out_ready = 1'b1;
         if (gap > 0 && i < 7) begin
            for (int g = 0; g < gap; g++) begin
               @(negedge clk);
               in_valid = 1'b0;
            end
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      if (rdy_last) out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int exp_q[4];
      rst_n     = 1'b0;
      in_sum    = '0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      clr_flags = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_level", int'(fifo_level), 0);
      chk("rst_data", int'(out_data), 0);
      chk("rst_sat", int'(sat_sticky), 0);
      chk("rst_drop", int'(drop_sticky), 0);
      rst_n = 1'b1;

      // basic average
      send_frame(1000, 0, 1'b0);
      chk("avg_valid", int'(out_valid), 1);
      chk("avg_data", int'(out_data), 16);
      chk("avg_sat", int'(sat_sticky), 0);
      @(negedge clk);
      chk("avg_valid_drop", int'(out_valid), 0);

      // saturation, flag clear, most-negative exact value
      send_frame(2097151, 0, 1'b0);
      chk("sat_data", int'(out_data), 32767);
      chk("sat_flag", int'(sat_sticky), 1);
      clr_flags = 1'b1;
      @(negedge clk);
      clr_flags = 1'b0;
      chk("sat_clr", int'(sat_sticky), 0);
      send_frame(-2097152, 0, 1'b0);
      chk("neg_full_data", int'(out_data), -32768);
      chk("neg_full_sat", int'(sat_sticky), 0);

      // negative rounding, contiguous and gapped
      for (int g = 0; g <= 3; g += 3) begin
         send_frame(-33, g, 1'b0);
         chk($sformatf("rnd_m33_g%0d", g), int'(out_data), -1);
         chk($sformatf("rnd_m33_v_g%0d", g), int'(out_valid), 1);
         send_frame(-32, g, 1'b0);
         chk($sformatf("rnd_m32_g%0d", g), int'(out_data), 0);
         chk($sformatf("rnd_m32_v_g%0d", g), int'(out_valid), 1);
      end
      @(negedge clk);
      chk("rnd_empty", int'(fifo_level), 0);

      // FIFO fill and drop
      out_ready = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         send_frame(512 * k, 0, 1'b0);
         chk($sformatf("fill_level_%0d", k), int'(fifo_level), k);
      end
      chk("fill_nodrop", int'(drop_sticky), 0);
      send_frame(2560, 0, 1'b0);
      chk("drop_level", int'(fifo_level), 4);
      chk("drop_flag", int'(drop_sticky), 1);
      chk("drop_head", int'(out_data), 8);
      repeat (2) @(negedge clk);
      chk("hold_head", int'(out_data), 8);
      out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("drain_%0d", k), int'(out_data), 8 * k);
         @(negedge clk);
      end
      chk("drain_level", int'(fifo_level), 0);
      chk("drain_valid", int'(out_valid), 0);

      // simultaneous push and pop while full
      out_ready = 1'b0;
      clr_flags = 1'b1;
      @(negedge clk);
      clr_flags = 1'b0;
      chk("clr_drop", int'(drop_sticky), 0);
      for (int k = 1; k <= 4; k++) send_frame(512 * k, 0, 1'b0);
      chk("pp_pre_level", int'(fifo_level), 4);
      send_frame(2560, 0, 1'b1);
      chk("pp_level", int'(fifo_level), 4);
      chk("pp_nodrop", int'(drop_sticky), 0);
      exp_q = '{16, 24, 32, 40};
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("pp_drain_%0d", k), int'(out_data), exp_q[k]);
         @(negedge clk);
      end
      chk("pp_empty", int'(fifo_level), 0);

      // reset mid-frame
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_sum   = 22'sd1000;
         in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("mrst_level", int'(fifo_level), 0);
      chk("mrst_valid", int'(out_valid), 0);
      send_frame(512, 0, 1'b0);
      chk("mrst_data", int'(out_data), 8);
      chk("mrst_level1", int'(fifo_level), 1);
      @(negedge clk);
      chk("mrst_single", int'(out_valid), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
